// File: rtl/ysyx_24100027_pkg.sv
// Shared constants for the instruction fetch unit: state encoding, reset PC
// and the bit positions of the instruction fields handed to decode.
package ysyx_24100027_pkg;

    localparam int          IFU_XLEN     = 32;
    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

    localparam int          STATE_W  = 3;
    localparam logic [2:0]  IFU_REQ  = 3'd0;
    localparam logic [2:0]  IFU_WAIT = 3'd1;
    localparam logic [2:0]  IFU_HOLD = 3'd2;
    localparam logic [2:0]  IFU_EXEC = 3'd3;
    localparam logic [2:0]  IFU_HALT = 3'd4;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int F3_LSB  = 12;
    localparam int F3_MSB  = 14;
    localparam int F7_LSB  = 25;
    localparam int F7_MSB  = 31;

    // A fetch target is usable only when it is word aligned.
    function automatic logic pc_aligned(input logic [1:0] pc_lsb);
        return (pc_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/ysyx_24100027_ifu_if.sv
// Bundle of the fetch unit's memory, decode and commit channels.
// master = fetch unit side, slave = memory/decode/execute side.
interface ysyx_24100027_ifu_if
    import ysyx_24100027_pkg::*;
#(
    parameter int XLEN = IFU_XLEN
) ();

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            commit_valid;
    logic [XLEN-1:0] next_pc;
    logic            fetch_misalign;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_addr,
        input  imem_resp_valid,
        input  imem_resp_data,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc,
        output opcode,
        output funct3,
        output funct7,
        input  commit_valid,
        input  next_pc,
        output fetch_misalign
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_addr,
        output imem_resp_valid,
        output imem_resp_data,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc,
        input  opcode,
        input  funct3,
        input  funct7,
        output commit_valid,
        output next_pc,
        input  fetch_misalign
    );

endinterface

// File: rtl/ysyx_24100027_reg.sv
// Generic width-parameterised register with asynchronous active-high reset
// to a configurable value and a load enable.
module ysyx_24100027_reg
    import ysyx_24100027_pkg::*;
#(
    parameter int               WIDTH   = IFU_XLEN,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Storage: reset wins asynchronously, otherwise load when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ysyx_24100027_ifu.sv
// Instruction fetch unit: one outstanding imem request, captured word held for
// decode, then a wait for the commit/next-PC before the following fetch.
module ysyx_24100027_ifu
    import ysyx_24100027_pkg::*;
#(
    parameter int              XLEN     = IFU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
    input  logic                clk,
    input  logic                rst,
    ysyx_24100027_ifu_if.master bus
);

    logic [STATE_W-1:0] state_r;
    logic [STATE_W-1:0] state_nxt_s;
    logic [XLEN-1:0]    pc_r;
    logic               pc_en_s;
    logic [XLEN-1:0]    inst_r;
    logic               inst_en_s;
    logic               misalign_r;
    logic               misalign_set_s;

    // Sequencing of the fetch/decode/execute loop and the load enables it drives.
    always_comb begin
        state_nxt_s    = state_r;
        pc_en_s        = 1'b0;
        inst_en_s      = 1'b0;
        misalign_set_s = 1'b0;
        case (state_r)
            IFU_REQ: begin
                if (bus.imem_req_ready) begin
                    state_nxt_s = IFU_WAIT;
                end else begin
                    state_nxt_s = IFU_REQ;
                end
            end
            IFU_WAIT: begin
                if (bus.imem_resp_valid) begin
                    inst_en_s   = 1'b1;
                    state_nxt_s = IFU_HOLD;
                end else begin
                    state_nxt_s = IFU_WAIT;
                end
            end
            IFU_HOLD: begin
                if (bus.inst_ready) begin
                    state_nxt_s = IFU_EXEC;
                end else begin
                    state_nxt_s = IFU_HOLD;
                end
            end
            IFU_EXEC: begin
                if (bus.commit_valid) begin
                    if (pc_aligned(bus.next_pc[1:0])) begin
                        pc_en_s     = 1'b1;
                        state_nxt_s = IFU_REQ;
                    end else begin
                        misalign_set_s = 1'b1;
                        state_nxt_s    = IFU_HALT;
                    end
                end else begin
                    state_nxt_s = IFU_EXEC;
                end
            end
            IFU_HALT: begin
                state_nxt_s = IFU_HALT;
            end
            // Illegal encodings park the unit until reset rather than fetch.
            default: begin
                state_nxt_s = IFU_HALT;
            end
        endcase
    end

    ysyx_24100027_reg #(.WIDTH(STATE_W), .RST_VAL(IFU_REQ)) u_state (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (state_nxt_s),
        .q   (state_r)
    );

    ysyx_24100027_reg #(.WIDTH(XLEN), .RST_VAL(RESET_PC)) u_pc (
        .clk (clk),
        .rst (rst),
        .en  (pc_en_s),
        .d   (bus.next_pc),
        .q   (pc_r)
    );

    // The instruction register is only loaded in WAIT, so decode never sees
    // the raw response bus.
    ysyx_24100027_reg #(.WIDTH(XLEN), .RST_VAL({XLEN{1'b0}})) u_inst (
        .clk (clk),
        .rst (rst),
        .en  (inst_en_s),
        .d   (bus.imem_resp_data),
        .q   (inst_r)
    );

    ysyx_24100027_reg #(.WIDTH(1), .RST_VAL(1'b0)) u_misalign (
        .clk (clk),
        .rst (rst),
        .en  (misalign_set_s),
        .d   (1'b1),
        .q   (misalign_r)
    );

    // pc only moves on an aligned commit, so it is also the PC of the held word.
    assign bus.imem_req_valid = (state_r == IFU_REQ);
    assign bus.imem_addr      = pc_r;
    assign bus.inst_valid     = (state_r == IFU_HOLD);
    assign bus.inst           = inst_r;
    assign bus.inst_pc        = pc_r;
    assign bus.opcode         = inst_r[OPC_MSB:OPC_LSB];
    assign bus.funct3         = inst_r[F3_MSB:F3_LSB];
    assign bus.funct7         = inst_r[F7_MSB:F7_LSB];
    assign bus.fetch_misalign = misalign_r;

endmodule

// File: tb/tb_ysyx_24100027_ifu.sv
// Self-checking bench for the fetch unit: directed scenarios with literal
// expectations, then randomized traffic checked against a transaction model.
module tb_ysyx_24100027_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    ysyx_24100027_ifu_if #(.XLEN(32)) bus ();

    ysyx_24100027_ifu #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: where the current instruction is in its life.
    logic [31:0] m_pc;
    logic [31:0] m_word;
    bit          m_accepted;   // request taken, word not yet returned
    bit          m_have_word;  // word captured for the current pc
    bit          m_delivered;  // decode has taken it, waiting for commit
    bit          m_halted;

    // Compare every cycle on the falling edge, then predict the rising edge.
    always @(negedge clk) begin
        bit exp_req;
        bit exp_iv;
        if (rst) begin
            m_pc = RST_PC; m_word = 32'h0;
            m_accepted = 0; m_have_word = 0; m_delivered = 0; m_halted = 0;
            chk("rst_inst_valid", {31'h0, bus.inst_valid}, 32'h0);
            chk("rst_misalign", {31'h0, bus.fetch_misalign}, 32'h0);
            chk("rst_inst", bus.inst, 32'h0);
            chk("rst_addr", bus.imem_addr, RST_PC);
        end else begin
            exp_req = !m_halted && !m_accepted && !m_have_word;
            exp_iv  = !m_halted && m_have_word && !m_delivered;
            chk("req_valid", {31'h0, bus.imem_req_valid}, {31'h0, exp_req});
            chk("addr", bus.imem_addr, m_pc);
            chk("inst_valid", {31'h0, bus.inst_valid}, {31'h0, exp_iv});
            chk("misalign", {31'h0, bus.fetch_misalign}, {31'h0, m_halted});
            if (m_have_word && !m_halted) begin
                chk("inst", bus.inst, m_word);
                chk("inst_pc", bus.inst_pc, m_pc);
                chk("opcode", {25'h0, bus.opcode}, m_word & 32'h7f);
                chk("funct3", {29'h0, bus.funct3}, (m_word >> 12) & 32'h7);
                chk("funct7", {25'h0, bus.funct7}, m_word >> 25);
            end
            if (m_halted) begin
                m_halted = 1;
            end else if (exp_req) begin
                if (bus.imem_req_ready) m_accepted = 1;
            end else if (m_accepted) begin
                if (bus.imem_resp_valid) begin
                    m_word = bus.imem_resp_data; m_have_word = 1; m_accepted = 0;
                end
            end else if (exp_iv) begin
                if (bus.inst_ready) m_delivered = 1;
            end else if (m_delivered && bus.commit_valid) begin
                if (bus.next_pc % 32'd4 == 32'd0) begin
                    m_pc = bus.next_pc; m_have_word = 0; m_delivered = 0;
                end else begin
                    m_halted = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.inst_ready      = 1'b0;
        bus.commit_valid    = 1'b0;
        bus.next_pc         = 32'h0;
    endtask

    // From REQ with ready high: accept, return word, hand it to decode.
    task automatic do_fetch(input logic [31:0] word);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = word;
        tick();
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'hdead_beef;
        bus.inst_ready      = 1'b1;
        tick();
        bus.inst_ready      = 1'b0;
    endtask

    task automatic commit(input logic [31:0] pc);
        bus.commit_valid = 1'b1;
        bus.next_pc      = pc;
        tick();
        bus.commit_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] tmp;
        int          r;
        int          halt_cnt;
        idle_inputs();
        rst = 1'b1;
        repeat (3) tick();
        chk("lit_reset_addr", bus.imem_addr, 32'h8000_0000);
        chk("lit_reset_inst", bus.inst, 32'h0);
        chk("lit_reset_iv", {31'h0, bus.inst_valid}, 32'h0);
        rst = 1'b0;

        // Request back-pressure: valid and address held steady.
        for (int i = 0; i < 3; i++) begin
            chk("lit_bp_req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
            chk("lit_bp_addr", bus.imem_addr, 32'h8000_0000);
            tick();
        end
        bus.imem_req_ready = 1'b1;
        tick();
        chk("lit_acc_req_drop", {31'h0, bus.imem_req_valid}, 32'h0);
        chk("lit_lat1_iv", {31'h0, bus.inst_valid}, 32'h0);
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h0010_0093;
        tick();
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h1234_5678;
        chk("lit_lat2_iv", {31'h0, bus.inst_valid}, 32'h1);
        chk("lit_opcode", {25'h0, bus.opcode}, 32'h13);
        chk("lit_funct3", {29'h0, bus.funct3}, 32'h0);
        chk("lit_funct7", {25'h0, bus.funct7}, 32'h0);
        chk("lit_inst_pc", bus.inst_pc, 32'h8000_0000);

        // Decode stall in HOLD with a stray commit pulse.
        for (int i = 0; i < 4; i++) begin
            bus.commit_valid = (i == 1);
            bus.next_pc      = 32'h8000_0200;
            tick();
            chk("lit_hold_inst", bus.inst, 32'h0010_0093);
            chk("lit_hold_pc", bus.inst_pc, 32'h8000_0000);
            chk("lit_hold_req", {31'h0, bus.imem_req_valid}, 32'h0);
            chk("lit_hold_iv", {31'h0, bus.inst_valid}, 32'h1);
        end
        bus.commit_valid = 1'b0;
        chk("lit_hold_commit_ignored", bus.imem_addr, 32'h8000_0000);
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        chk("lit_exec_iv", {31'h0, bus.inst_valid}, 32'h0);
        chk("lit_exec_inst", bus.inst, 32'h0010_0093);
        tick();
        commit(32'h8000_0004);
        chk("lit_seq_req", {31'h0, bus.imem_req_valid}, 32'h1);
        chk("lit_seq_addr", bus.imem_addr, 32'h8000_0004);

        // Jump, then a misaligned target.
        do_fetch(32'h0000_0013);
        commit(32'h8000_0100);
        chk("lit_jump_addr", bus.imem_addr, 32'h8000_0100);
        do_fetch(32'h0000_006f);
        commit(32'h8000_0102);
        chk("lit_mis_flag", {31'h0, bus.fetch_misalign}, 32'h1);
        chk("lit_mis_pc", bus.imem_addr, 32'h8000_0100);
        for (int i = 0; i < 20; i++) begin
            bus.commit_valid = (i % 5 == 0);
            bus.next_pc      = 32'h8000_0000;
            tick();
            chk("lit_halt_req", {31'h0, bus.imem_req_valid}, 32'h0);
        end
        bus.commit_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("lit_rst_mis_clear", {31'h0, bus.fetch_misalign}, 32'h0);
        chk("lit_rst_addr", bus.imem_addr, 32'h8000_0000);
        tick();
        rst = 1'b0;

        // Response during REQ is ignored; then async reset in WAIT.
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hdead_beef;
        tick();
        bus.imem_resp_valid = 1'b0;
        chk("lit_req_resp_iv", {31'h0, bus.inst_valid}, 32'h0);
        chk("lit_req_resp_req", {31'h0, bus.imem_req_valid}, 32'h1);
        do_fetch(32'h0020_8133);
        commit(32'h8000_0040);
        tick();
        chk("lit_wait_req", {31'h0, bus.imem_req_valid}, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("lit_async_addr", bus.imem_addr, 32'h8000_0000);
        chk("lit_async_iv", {31'h0, bus.inst_valid}, 32'h0);
        chk("lit_async_inst", bus.inst, 32'h0);
        chk("lit_async_req", {31'h0, bus.imem_req_valid}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();

        // Randomized traffic against the model.
        halt_cnt = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            if (m_accepted) begin
                bus.imem_resp_valid = ($urandom_range(0, 1) == 1);
            end else begin
                bus.imem_resp_valid = ($urandom_range(0, 7) == 0);
            end
            bus.imem_resp_data = $urandom;
            bus.inst_ready     = ($urandom_range(0, 1) == 1);
            if (m_delivered && !m_halted) begin
                bus.commit_valid = ($urandom_range(0, 2) == 0);
                r = $urandom_range(0, 99);
                tmp = $urandom;
                if (r < 70)      bus.next_pc = m_pc + 32'd4;
                else if (r < 93) bus.next_pc = tmp & 32'hffff_fffc;
                else if (r < 97) bus.next_pc = 32'hffff_fffc;
                else             bus.next_pc = m_pc + 32'd4 + 32'($urandom_range(1, 3));
            end else begin
                bus.commit_valid = ($urandom_range(0, 7) == 0);
                bus.next_pc      = $urandom;
            end
            if (m_halted) halt_cnt++;
            if (halt_cnt > 12 || $urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                halt_cnt = 0;
            end else begin
                rst = 1'b0;
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_24100027_ifu.md
Name: ysyx_24100027_ifu

Overview:
Instruction fetch unit, directly upstream of the decode stage. Holds the architectural PC and issues one instruction-memory request at a time over a valid/ready request channel. It captures the response word and presents the instruction, together with its pre-sliced opcode/funct3/funct7 fields, to decode via a valid/ready handshake. It then waits for the commit/next-PC from execute before fetching again, giving a multi-cycle, non-pipelined fetch–decode–execute loop.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
XLEN, 32, width of the PC and of instruction words

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts the request
imem_addr  output  XLEN  fetch address (always the current PC)
imem_resp_valid  input  1  response word valid; memory has no back-pressure on responses
imem_resp_data  input  XLEN  instruction word
inst_valid  output  1  instruction available to decode
inst_ready  input  1  decode accepts the instruction
inst  output  XLEN  captured instruction word
inst_pc  output  XLEN  PC of the captured instruction
opcode  output  7  inst[6:0]
funct3  output  3  inst[14:12]
funct7  output  7  inst[31:25]
commit_valid  input  1  execute done; next_pc is valid for one cycle
next_pc  input  XLEN  PC of the next instruction (pc+4, branch or jump target)
fetch_misalign  output  1  sticky flag: next_pc[1:0] != 0 was received; the unit is halted

Behaviour:
- States: REQ, WAIT, HOLD, EXEC, HALT. Encoding is 3 bits.
- Reset (async, any state, including mid-transaction): state=REQ, pc=RESET_PC, inst=0, fetch_misalign=0. All valid outputs are 0, except imem_req_valid, which is 1 on the first cycle after reset.
- REQ: imem_req_valid=1, imem_addr=pc. If imem_req_ready=1, go to WAIT. imem_addr must stay stable while valid and not ready.
- WAIT: imem_req_valid=0. On imem_resp_valid=1, latch inst<=imem_resp_data and go to HOLD. The same-cycle request/response case does not occur, because a response is only accepted in WAIT.
- HOLD: inst_valid=1, and inst/inst_pc/field outputs stay stable until the handshake. When inst_ready=1, go to EXEC. There is no combinational path from imem_resp_data to inst; minimum latency from request acceptance to inst_valid is 2 cycles.
- EXEC: inst_valid=0, and inst stays stable so decode/execute may continue to read fields. On commit_valid=1:
  - if next_pc[1:0]==0: pc<=next_pc, go to REQ;
  - otherwise: fetch_misalign<=1, pc is unchanged, go to HALT.
- HALT: absorbing; only reset exits.
- commit_valid outside EXEC is ignored, and pc is not modified.
- imem_resp_valid outside WAIT is ignored. A response still in flight across a reset is the memory's responsibility: the memory resets with the same rst.
- The PC wraps modulo 2^XLEN; no special case is made at 32'hFFFF_FFFC.
- inst_pc equals the pc latched at REQ acceptance and is constant through HOLD and EXEC.
- The environment trap (ebreak) is handled in decode, not here.

Decomposition:
- Shared package (ysyx_24100027_pkg): state encoding constants (IFU_REQ/WAIT/HOLD/EXEC/HALT), RESET_PC default, and instruction field bit positions (OPC_LSB/MSB, F3, F7).
- One sub-module is natural: ysyx_24100027_reg, a generic width-parameterised async-reset register with enable and reset value. It is used for pc, inst and state.

Test Plan:
- Reset then ready held 1, memory returns 32'h0010_0093 one cycle after acceptance. Required response:
  - imem_addr=32'h8000_0000;
  - inst_valid rises 2 cycles after acceptance;
  - opcode=7'h13, funct3=0, funct7=0, inst_pc=32'h8000_0000.
- Back-pressure: imem_req_ready low for 3 cycles. imem_req_valid and imem_addr must hold 32'h8000_0000 steady, and there is no state change until ready.
- inst_ready low for 4 cycles in HOLD. inst, inst_pc and fields must stay stable, and no second imem request is issued. After commit_valid with next_pc=32'h8000_0004, the next imem_addr is 32'h8000_0004.
- Jump: commit_valid with next_pc=32'h8000_0100. The next fetch address is 32'h8000_0100. A commit_valid pulse in HOLD is ignored: pc is unchanged.
- Misaligned target: next_pc=32'h8000_0102. Required response: fetch_misalign=1 next cycle, imem_req_valid stays 0 for 20 cycles, and reset clears the flag and restarts at 32'h8000_0000.
- Async reset asserted mid-WAIT, between clock edges. Outputs clear immediately. After deassertion, a fresh fetch from RESET_PC occurs, and a resp_valid pulse during REQ is ignored.
